ahb_tanh_seq: RTL and testbench

- AHB-Lite slave that batch-processes packed int8 activations through the shared combinational 8-bit tanh LUT (in[7:0] -> out[7:0]).
- Software pushes 32-bit words, each holding 4 bytes, into an input FIFO.
- A sequencer FSM feeds the LUT one byte per cycle, repacks the results and pushes them to an output FIFO.
- Sits on the accelerator AHB segment beside the single-shot tanh slave; adds buffering, status and an interrupt.

---
 rtl/ahb_tanh_seq.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_ahb_tanh_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_tanh_seq.sv
`default_nettype none
// ============================================================================
// Module   : ahb_tanh_seq
// Purpose  : AHB-Lite slave that batch-processes packed int8 activations.
//            Words written to IN are queued, split into 4 bytes, each byte
//            passed through the 8-bit tanh LUT (one byte per cycle), repacked
//            and queued for readout at OUT. Provides status, a sticky
//            overflow/underflow pair and a level interrupt on completion.
// Ports    : HCLK/HRESET        clock, asynchronous active-high reset
//            HSEL/HREADY/HTRANS address-phase qualifiers
//            HSIZE              ignored (all accesses are word accesses)
//            HWRITE/HADDR       direction and address (only [7:0] decoded)
//            HWDATA             write data (data phase)
//            HREADYOUT/HRESP    tied to 1 / 2'b00
//            HRDATA             read data, from the registered address
//            IRQ                irq_en & done
// Register : 0x00 IN (W), 0x04 OUT (R, pops), 0x08 STATUS (R),
//            0x0C CTRL (R/W: [0] irq_en, [1] flush), 0x10 ISR (R/W1C: [0]),
//            0x14 PERF (R, write clears) when TANH_SEQ_PERF_EN is defined.
// Macro    : TANH_SEQ_PERF_EN enables the completed-word counter at 0x14.
// Revision : 1.0 - initial release
// ============================================================================
module ahb_tanh_seq #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic        HREADY,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA,
  output logic        IRQ
);

  localparam int             AW     = CW - 1;
  localparam logic [CW-1:0]  c_full = CW'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_STORE = 2'd2
  } state_t;

  // --------------------------------------------------------------------------
  // tanh LUT: out = clamp(round(128 * tanh(x / 16)), -128, 127).
  // Only the magnitude curve is stored; it saturates at 128 from |x| = 50.
  // --------------------------------------------------------------------------
  function automatic logic [7:0] f_tanh_mag(input logic [7:0] m);
    logic [7:0] v;
    case (m)
      8'd0:  v = 8'd0;   8'd1:  v = 8'd8;   8'd2:  v = 8'd16;  8'd3:  v = 8'd24;
      8'd4:  v = 8'd31;  8'd5:  v = 8'd39;  8'd6:  v = 8'd46;  8'd7:  v = 8'd53;
      8'd8:  v = 8'd59;  8'd9:  v = 8'd65;  8'd10: v = 8'd71;  8'd11: v = 8'd76;
      8'd12: v = 8'd81;  8'd13: v = 8'd86;  8'd14: v = 8'd90;  8'd15: v = 8'd94;
      8'd16: v = 8'd97;  8'd17: v = 8'd101; 8'd18: v = 8'd104; 8'd19: v = 8'd106;
      8'd20: v = 8'd109; 8'd21: v = 8'd111; 8'd22: v = 8'd113; 8'd23: v = 8'd114;
      8'd24: v = 8'd116; 8'd25: v = 8'd117; 8'd26: v = 8'd118; 8'd27: v = 8'd120;
      8'd28: v = 8'd120; 8'd29: v = 8'd121; 8'd30: v = 8'd122; 8'd31: v = 8'd123;
      8'd32: v = 8'd123; 8'd33: v = 8'd124; 8'd34: v = 8'd124; 8'd35: v = 8'd125;
      8'd36: v = 8'd125; 8'd37: v = 8'd126; 8'd38: v = 8'd126; 8'd39: v = 8'd126;
      8'd40: v = 8'd126; 8'd41: v = 8'd126; 8'd42: v = 8'd127; 8'd43: v = 8'd127;
      8'd44: v = 8'd127; 8'd45: v = 8'd127; 8'd46: v = 8'd127; 8'd47: v = 8'd127;
      8'd48: v = 8'd127; 8'd49: v = 8'd127;
      default: v = 8'd128;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] f_tanh(input logic [7:0] x);
    logic [7:0] mag;
    logic [7:0] v;
    if (x[7]) begin
      // -128 negates to 128 in 8 bits, which the curve maps to 128 -> 0x80.
      mag = ~x + 8'd1;
      v   = f_tanh_mag(mag);
      v   = ~v + 8'd1;
    end else begin
      v = f_tanh_mag(x);
      if (v == 8'd128) v = 8'd127;
    end
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic          r_wr, r_rd;
  logic [7:0]    r_addr;
  logic [31:0]   r_in_mem  [DEPTH];
  logic [31:0]   r_out_mem [DEPTH];
  logic [AW-1:0] r_in_wp, r_in_rp, r_out_wp, r_out_rp;
  logic [CW-1:0] r_in_cnt, r_out_cnt;
  logic          r_irq_en, r_done, r_ovf, r_udf;
  state_t        r_state;
  logic [1:0]    r_k;
  logic [31:0]   r_word, r_res;
`ifdef TANH_SEQ_PERF_EN
  logic [31:0]   r_perf;
`endif

  logic w_access, w_wr_in, w_rd_out, w_wr_ctrl, w_wr_isr, w_flush;
  logic w_in_full, w_in_empty, w_out_full, w_out_empty;
  logic w_in_push, w_in_pop, w_out_push, w_out_pop;
  logic w_unused_bits;

  assign w_unused_bits = ^{HSIZE, HADDR[31:8]};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 2'b00;
  assign IRQ       = r_irq_en & r_done;

  assign w_access   = HSEL & HREADY & HTRANS[1];
  assign w_wr_in    = r_wr & (r_addr == 8'h00);
  assign w_rd_out   = r_rd & (r_addr == 8'h04);
  assign w_wr_ctrl  = r_wr & (r_addr == 8'h0C);
  assign w_wr_isr   = r_wr & (r_addr == 8'h10);
  assign w_flush    = w_wr_ctrl & HWDATA[1];

  assign w_in_full   = (r_in_cnt == c_full);
  assign w_in_empty  = (r_in_cnt == '0);
  assign w_out_full  = (r_out_cnt == c_full);
  assign w_out_empty = (r_out_cnt == '0);

  assign w_in_push  = w_wr_in & ~w_in_full;
  // The only consumer of the output FIFO is the bus, so a free slot seen in
  // IDLE is still free when the word reaches STORE.
  assign w_in_pop   = (r_state == S_IDLE) & ~w_in_empty & ~w_out_full & ~w_flush;
  assign w_out_push = (r_state == S_STORE) & ~w_flush;
  assign w_out_pop  = w_rd_out & ~w_out_empty & ~w_flush;

  // --------------------------------------------------------------------------
  // Address-phase capture
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wr   <= 1'b0;
      r_rd   <= 1'b0;
      r_addr <= 8'h00;
    end else begin
      r_wr <= w_access & HWRITE;
      r_rd <= w_access & ~HWRITE;
      if (w_access) r_addr <= HADDR[7:0];
    end
  end

  // --------------------------------------------------------------------------
  // Input FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) r_in_mem[i] <= '0;
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else if (w_flush) begin
      r_in_wp  <= '0;
      r_in_rp  <= '0;
      r_in_cnt <= '0;
    end else begin
      if (w_in_push) begin
        r_in_mem[r_in_wp] <= HWDATA;
        r_in_wp           <= r_in_wp + AW'(1);
      end
      if (w_in_pop) r_in_rp <= r_in_rp + AW'(1);
      r_in_cnt <= r_in_cnt + CW'(w_in_push) - CW'(w_in_pop);
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) r_out_mem[i] <= '0;
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else if (w_flush) begin
      r_out_wp  <= '0;
      r_out_rp  <= '0;
      r_out_cnt <= '0;
    end else begin
      if (w_out_push) begin
        r_out_mem[r_out_wp] <= r_res;
        r_out_wp            <= r_out_wp + AW'(1);
      end
      if (w_out_pop) r_out_rp <= r_out_rp + AW'(1);
      r_out_cnt <= r_out_cnt + CW'(w_out_push) - CW'(w_out_pop);
    end
  end

  // --------------------------------------------------------------------------
  // Sequencer: the word shifts right one byte per CONV cycle while results
  // shift in from the top, so after four cycles result byte k sits in lane k.
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
      r_word  <= '0;
      r_res   <= '0;
    end else if (w_flush) begin
      r_state <= S_IDLE;
      r_k     <= 2'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_in_pop) begin
            r_word  <= r_in_mem[r_in_rp];
            r_k     <= 2'd0;
            r_state <= S_CONV;
          end
        end
        S_CONV: begin
          r_res  <= {f_tanh(r_word[7:0]), r_res[31:8]};
          r_word <= {8'h00, r_word[31:8]};
          r_k    <= r_k + 2'd1;
          if (r_k == 2'd3) r_state <= S_STORE;
        end
        S_STORE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Control / status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_irq_en <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= HWDATA[0];
      if (w_flush) begin
        r_done <= 1'b0;
        r_ovf  <= 1'b0;
        r_udf  <= 1'b0;
      end else begin
        if (w_wr_in & w_in_full)    r_ovf <= 1'b1;
        if (w_rd_out & w_out_empty) r_udf <= 1'b1;
        // Set is evaluated last so it beats a same-edge W1C.
        if (w_wr_isr & HWDATA[0])   r_done <= 1'b0;
        if (w_out_push)             r_done <= 1'b1;
      end
    end
  end

`ifdef TANH_SEQ_PERF_EN
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_perf <= '0;
    end else if (w_flush || (r_wr && r_addr == 8'h14)) begin
      r_perf <= '0;
    end else if (w_out_push) begin
      r_perf <= r_perf + 32'd1;
    end
  end
`endif

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    HRDATA = 32'h0;
    case (r_addr)
      8'h04: HRDATA = w_out_empty ? 32'h0 : r_out_mem[r_out_rp];
      8'h08: HRDATA = {8'h00, 8'(r_out_cnt), 8'(r_in_cnt), 1'b0, r_udf, r_ovf,
                       (r_state != S_IDLE), w_out_empty, w_out_full,
                       w_in_empty, w_in_full};
      8'h0C: HRDATA = {31'h0, r_irq_en};
      8'h10: HRDATA = {31'h0, r_done};
`ifdef TANH_SEQ_PERF_EN
      8'h14: HRDATA = r_perf;
`endif
      default: HRDATA = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_tanh_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_tanh_seq
// Purpose  : Self-checking bench for ahb_tanh_seq. Expected OUT words are
//            queued when IN writes are issued and compared on readout.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_tanh_seq;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL, HREADY, HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [31:0] HADDR, HWDATA;
  logic        HREADYOUT;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic        IRQ;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  ahb_tanh_seq #(.DEPTH(4), .CW(3)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HREADY(HREADY),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .HRDATA(HRDATA), .IRQ(IRQ)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Reference tanh: clamp(round(128 * tanh(x/16)), -128, 127)
  function automatic logic [7:0] m_tanh(input logic [7:0] x);
    real r;
    int  xi;
    int  v;
    xi = $signed(x);
    r  = 128.0 * $tanh($itor(xi) / 16.0);
    if (r >= 0.0) v = $rtoi(r + 0.5);
    else          v = -$rtoi(0.5 - r);
    if (v > 127)  v = 127;
    if (v < -128) v = -128;
    return v[7:0];
  endfunction

  function automatic logic [31:0] m_word(input logic [31:0] w);
    return {m_tanh(w[31:24]), m_tanh(w[23:16]), m_tanh(w[15:8]), m_tanh(w[7:0])};
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Pipelined AHB accesses: each task drives one address phase; the data
  // phase completes on the edge after the task returns.
  task automatic ahb_wr(input logic [7:0] a, input logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
  endtask

  task automatic ahb_rd(input logic [7:0] a, output logic [31:0] d);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    d = HRDATA;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic push_in(input logic [31:0] w);
    ahb_wr(8'h00, w);
    exp_q.push_back(m_word(w));
  endtask

  task automatic read_out(input string tag);
    logic [31:0] d;
    ahb_rd(8'h04, d);
    if (exp_q.size() == 0) check(tag, d, 32'h0);
    else                   check(tag, d, exp_q.pop_front());
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] d;
    ahb_rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wait_out(input string tag, input int n);
    logic [31:0] s;
    s = 32'h0;
    for (int i = 0; i < 200; i++) begin
      ahb_rd(8'h08, s);
      if (int'(s[23:16]) >= n) break;
    end
    check(tag, {24'h0, s[23:16]}, n);
  endtask

  initial begin
    logic [31:0] w;
    HRESET = 1'b1; HSEL = 1'b0; HREADY = 1'b1; HTRANS = 2'b00; HSIZE = 3'b010;
    HWRITE = 1'b0; HADDR = 32'h0; HWDATA = 32'h0;

    // Reset state
    repeat (3) @(posedge HCLK);
    #1;
    check("rst_irq", {31'h0, IRQ}, 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
    check("rst_hresp", {30'h0, HRESP}, 32'h0);
    #3 HRESET = 1'b0;
    wait_cyc(1);
    rd_chk("rst_status", 8'h08, 32'h0000_000A);

    // Basic word, exact latency
    ahb_wr(8'h00, 32'hFF10_0100);
    exp_q.push_back(32'hF861_0800);
    wait_cyc(5);
    rd_chk("lat_status_e5", 8'h08, 32'h0000_001A);
    rd_chk("lat_status_e6", 8'h08, 32'h0001_0002);
    read_out("out_basic");
    rd_chk("isr_done", 8'h10, 32'h1);
    rd_chk("status_after_pop", 8'h08, 32'h0000_000A);

    // Interrupt
    ahb_wr(8'h10, 32'h1);
    ahb_wr(8'h0C, 32'h1);
    wait_cyc(1);
    check("irq_cleared", {31'h0, IRQ}, 32'h0);
    ahb_wr(8'h00, 32'h807F_0000);
    exp_q.push_back(32'h807F_0000);
    wait_cyc(6);
    check("irq_before_store", {31'h0, IRQ}, 32'h0);
    wait_cyc(1);
    check("irq_after_store", {31'h0, IRQ}, 32'h1);
    read_out("out_irq");
    ahb_wr(8'h10, 32'h1);
    wait_cyc(1);
    check("irq_w1c", {31'h0, IRQ}, 32'h0);
    ahb_wr(8'h0C, 32'h0);

    // LUT sweep: every byte value appears in some lane
    for (int i = 0; i < 64; i++) begin
      w = {8'(i + 192), 8'(i + 128), 8'(i + 64), 8'(i)};
      push_in(w);
      wait_cyc(7);
      read_out($sformatf("sweep_%0d", i));
    end

    // Fill output, then overflow the input FIFO
    for (int i = 0; i < 4; i++) push_in(32'h1000_0000 + 32'(i * 32'h0102_0304));
    wait_out("fill_out_count", 4);
    for (int i = 0; i < 5; i++) begin
      w = 32'hA0B0_C0D0 ^ 32'(i * 32'h1111_1111);
      ahb_wr(8'h00, w);
      if (i < 4) exp_q.push_back(m_word(w));
    end
    wait_cyc(10);
    rd_chk("ovf_status", 8'h08, 32'h0004_0425);
    for (int i = 0; i < 4; i++) read_out($sformatf("drain_a%0d", i));
    wait_out("refill_out_count", 4);
    for (int i = 0; i < 4; i++) read_out($sformatf("drain_b%0d", i));
    rd_chk("post_drain_status", 8'h08, 32'h0000_002A);

    // Underflow and flush
    read_out("udf_read");
    rd_chk("udf_status", 8'h08, 32'h0000_006A);
    ahb_wr(8'h0C, 32'h2);
    rd_chk("flush_status", 8'h08, 32'h0000_000A);
    rd_chk("flush_ctrl", 8'h0C, 32'h0);
    rd_chk("flush_isr", 8'h10, 32'h0);

    // Flush aborts a word in flight
    ahb_wr(8'h00, 32'h1234_5678);
    wait_cyc(2);
    ahb_wr(8'h0C, 32'h2);
    wait_cyc(10);
    rd_chk("flush_abort_status", 8'h08, 32'h0000_000A);

    // Asynchronous reset in the second CONV cycle
    ahb_wr(8'h0C, 32'h1);
    push_in(32'h0102_0304);
    wait_cyc(7);
    read_out("pre_reset_out");
    check("pre_reset_irq", {31'h0, IRQ}, 32'h1);
    ahb_wr(8'h00, 32'h7F80_40C0);
    wait_cyc(3);
    #2 HRESET = 1'b1;
    #1;
    check("async_rst_irq", {31'h0, IRQ}, 32'h0);
    check("async_rst_hrdata", HRDATA, 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    wait_cyc(1);
    rd_chk("post_rst_status", 8'h08, 32'h0000_000A);
    rd_chk("post_rst_ctrl", 8'h0C, 32'h0);
    push_in(32'hC0E0_2040);
    wait_cyc(7);
    read_out("post_rst_out");
    rd_chk("unmapped_rd", 8'h20, 32'h0);

`ifdef TANH_SEQ_PERF_EN
    ahb_wr(8'h0C, 32'h2);
    for (int i = 0; i < 3; i++) begin
      push_in(32'h0F0E_0D0C + 32'(i));
      wait_cyc(7);
      read_out($sformatf("perf_out_%0d", i));
    end
    rd_chk("perf_count", 8'h14, 32'd3);
    ahb_wr(8'h14, 32'h0);
    rd_chk("perf_clear", 8'h14, 32'd0);
`else
    rd_chk("perf_absent", 8'h14, 32'd0);
`endif

    wait_cyc(2);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
